// File: rtl/datapath_write_arbiter_if.sv
// Bundle shared by the R1 write arbiter, its requesters and the DataPath R1 port.
interface datapath_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ERR_W   = 8
) ();
  localparam int unsigned ID_W = 2;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      write_enable1;
  logic [DATA_W-1:0]         write_data1;
  logic [DATA_W-1:0]         read_data1;
  logic                      busy;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic                      mismatch;
  logic [ERR_W-1:0]          err_count;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, read_data1,
    output req_ready, write_enable1, write_data1, busy, done, done_id, mismatch, err_count
  );

  // Requesters / DataPath / environment side.
  modport master (
    output req_valid, req_data, read_data1,
    input  req_ready, write_enable1, write_data1, busy, done, done_id, mismatch, err_count
  );
endinterface

// File: rtl/datapath_write_arbiter.sv
// Round-robin arbiter sharing the DataPath R1 write port; each grant is written
// for one cycle, read back the following cycle and reported with a mismatch flag.
module datapath_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ERR_W   = 8
) (
  input logic                      clock,
  input logic                      clear,
  datapath_write_arbiter_if.slave  bus
);
  localparam int unsigned ID_W = 2;

  typedef enum logic [1:0] {IDLE, WRITE, CHECK} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              mis_q, mis_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              grant_vld_c;
  logic [ID_W-1:0]   grant_id_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic              rb_mis_c;

  // Circular priority scan starting at the round-robin pointer.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_vld_c && bus.req_valid[idx]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = idx;
      end
    end
  end

  assign rb_mis_c = (bus.read_data1 != data_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    data_d      = data_q;
    we_d        = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    mis_d       = 1'b0;
    err_d       = err_q;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          req_ready_c[grant_id_c] = 1'b1;
          id_d    = grant_id_c;
          data_d  = bus.req_data[32'(grant_id_c)*DATA_W +: DATA_W];
          rr_d    = ID_W'((32'(grant_id_c) + 32'd1) % NUM_REQ);
          we_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy_d  = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        // R1 holds the written value now; the result is reported in the next IDLE cycle.
        done_d    = 1'b1;
        done_id_d = id_q;
        mis_d     = rb_mis_c;
        if (rb_mis_c && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + ERR_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      mis_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      data_q    <= data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end

  // Acceptance is combinational and suppressed while the block is held in reset.
  assign bus.req_ready     = clear ? req_ready_c : '0;
  assign bus.write_enable1 = we_q;
  assign bus.write_data1   = data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.done_id       = done_id_q;
  assign bus.mismatch      = mis_q;
  assign bus.err_count     = err_q;

endmodule

// File: tb/tb_datapath_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-timestamp model of the arbiter and a bench-side R1 register.
module tb_datapath_write_arbiter;
  logic clock;
  logic clear;
  logic force_bad;
  logic [7:0] r1;

  int n_chk = 0;
  int n_err = 0;

  datapath_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .ERR_W(8)) bus_if ();

  datapath_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .ERR_W(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DataPath R1 stand-in; force_bad corrupts the readback.
  always @(posedge clock or negedge clear) begin
    if (!clear) r1 <= 8'd0;
    else if (bus_if.write_enable1) r1 <= bus_if.write_data1;
  end
  assign bus_if.read_data1 = force_bad ? 8'hFF : r1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint cyc = 0;
  longint g_cyc = 0;
  longint done_at = -1;
  logic       m_act = 1'b0;
  logic [1:0] m_ptr = 2'd0;
  logic [1:0] g_id = 2'd0;
  logic [1:0] d_id = 2'd0;
  logic [7:0] g_data = 8'd0;
  logic [7:0] m_wd = 8'd0;
  logic       d_mis = 1'b0;
  int         m_err = 0;

  always @(negedge clock) begin
    logic idle, e_we, e_busy, e_done;
    logic [3:0] e_ready;
    if (!clear) begin
      m_act = 1'b0; done_at = -1; m_ptr = 2'd0; m_err = 0; m_wd = 8'd0;
      chk("rst_we",    32'(bus_if.write_enable1), 32'd0);
      chk("rst_wdata", 32'(bus_if.write_data1),   32'd0);
      chk("rst_busy",  32'(bus_if.busy),          32'd0);
      chk("rst_done",  32'(bus_if.done),          32'd0);
      chk("rst_mis",   32'(bus_if.mismatch),      32'd0);
      chk("rst_err",   32'(bus_if.err_count),     32'd0);
      chk("rst_ready", 32'(bus_if.req_ready),     32'd0);
    end else begin
      idle   = !m_act;
      e_we   = m_act && (cyc == g_cyc + 1);
      e_busy = m_act && ((cyc == g_cyc + 1) || (cyc == g_cyc + 2));
      if (e_we) m_wd = g_data;
      e_done = (done_at == cyc);
      if (e_done && d_mis && m_err < 255) m_err++;
      if (m_act && (cyc == g_cyc + 2)) begin
        d_id    = g_id;
        d_mis   = (bus_if.read_data1 != g_data);
        done_at = cyc + 1;
        m_act   = 1'b0;
      end
      e_ready = 4'd0;
      if (idle) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (int'(m_ptr) + k) % 4;
          if (e_ready == 4'd0 && bus_if.req_valid[idx]) begin
            e_ready[idx] = 1'b1;
            g_id   = 2'(idx);
            g_data = bus_if.req_data[idx*8 +: 8];
            g_cyc  = cyc;
            m_act  = 1'b1;
            m_ptr  = 2'((idx + 1) % 4);
          end
        end
      end
      chk("m_we",    32'(bus_if.write_enable1), 32'(e_we));
      chk("m_wdata", 32'(bus_if.write_data1),   32'(m_wd));
      chk("m_busy",  32'(bus_if.busy),          32'(e_busy));
      chk("m_done",  32'(bus_if.done),          32'(e_done));
      chk("m_mis",   32'(bus_if.mismatch),      32'(e_done && d_mis));
      if (e_done) chk("m_done_id", 32'(bus_if.done_id), 32'(d_id));
      chk("m_err",   32'(bus_if.err_count),     32'(m_err));
      chk("m_ready", 32'(bus_if.req_ready),     32'(e_ready));
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    bus_if.req_valid = 4'd0;
    tick();
    tick();
    clear = 1'b1;
  endtask

  initial begin
    logic [7:0] d4 [4];
    logic [1:0] ord3 [3];
    d4[0] = 8'd10; d4[1] = 8'd20; d4[2] = 8'd30; d4[3] = 8'd40;
    ord3[0] = 2'd0; ord3[1] = 2'd2; ord3[2] = 2'd0;

    clear = 1'b0;
    force_bad = 1'b0;
    bus_if.req_valid = 4'b1111;
    bus_if.req_data  = 32'd0;
    @(negedge clock);
    chk("reset_ready_gated", 32'(bus_if.req_ready), 32'd0);
    chk("reset_err", 32'(bus_if.err_count), 32'd0);
    tick();
    bus_if.req_valid = 4'd0;
    tick();
    clear = 1'b1;
    tick();

    // Single write from requester 0.
    bus_if.req_valid = 4'b0001;
    bus_if.req_data[7:0] = 8'd123;
    @(negedge clock);
    chk("t1_ready", 32'(bus_if.req_ready), 32'h1);
    tick();
    bus_if.req_valid = 4'd0;
    @(negedge clock);
    chk("t1_we", 32'(bus_if.write_enable1), 32'd1);
    chk("t1_wdata", 32'(bus_if.write_data1), 32'd123);
    tick();
    tick();
    @(negedge clock);
    chk("t1_done", 32'(bus_if.done), 32'd1);
    chk("t1_done_id", 32'(bus_if.done_id), 32'd0);
    chk("t1_mis", 32'(bus_if.mismatch), 32'd0);
    chk("t1_r1", 32'(bus_if.read_data1), 32'd123);
    tick();

    // All four requesting continuously.
    do_reset();
    bus_if.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus_if.req_data[i*8 +: 8] = d4[i];
    for (int g = 0; g < 5; g++) begin
      @(negedge clock);
      chk("t2_ready", 32'(bus_if.req_ready), 32'(4'b0001 << (g % 4)));
      if (g > 0) begin
        chk("t2_done", 32'(bus_if.done), 32'd1);
        chk("t2_done_id", 32'(bus_if.done_id), 32'((g - 1) % 4));
      end
      tick();
      if (g == 4) bus_if.req_valid = 4'd0;
      @(negedge clock);
      chk("t2_wdata", 32'(bus_if.write_data1), 32'(d4[g % 4]));
      tick();
      @(negedge clock);
      chk("t2_r1", 32'(bus_if.read_data1), 32'(d4[g % 4]));
      tick();
    end
    @(negedge clock);
    chk("t2_last_done_id", 32'(bus_if.done_id), 32'd0);
    chk("t2_err", 32'(bus_if.err_count), 32'd0);
    tick();

    // Requesters 0 and 2 only.
    do_reset();
    bus_if.req_valid = 4'b0101;
    bus_if.req_data  = 32'h0033_2211;
    for (int g = 0; g < 3; g++) begin
      @(negedge clock);
      chk("t3_ready", 32'(bus_if.req_ready), 32'(4'b0001 << ord3[g]));
      tick();
      if (g == 2) bus_if.req_valid = 4'd0;
      tick();
      tick();
    end
    tick();

    // Forced readback error and saturation.
    do_reset();
    force_bad = 1'b1;
    bus_if.req_valid = 4'b0001;
    bus_if.req_data  = 32'h0000_000F;
    tick();
    tick();
    tick();
    @(negedge clock);
    chk("t4_done", 32'(bus_if.done), 32'd1);
    chk("t4_mis", 32'(bus_if.mismatch), 32'd1);
    chk("t4_err1", 32'(bus_if.err_count), 32'd1);
    repeat (900) tick();
    bus_if.req_valid = 4'd0;
    repeat (5) tick();
    @(negedge clock);
    chk("t4_err_sat", 32'(bus_if.err_count), 32'd255);
    force_bad = 1'b0;
    tick();

    // Reset during WRITE.
    do_reset();
    bus_if.req_valid = 4'b0001;
    bus_if.req_data  = 32'h0000_0055;
    tick();
    bus_if.req_valid = 4'd0;
    chk("t5_we_before", 32'(bus_if.write_enable1), 32'd1);
    #2 clear = 1'b0;
    #1 chk("t5_we_dropped", 32'(bus_if.write_enable1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t5_no_done", 32'(bus_if.done), 32'd0);
      tick();
    end
    clear = 1'b1;
    bus_if.req_valid = 4'b0010;
    bus_if.req_data  = 32'h0000_6600;
    @(negedge clock);
    chk("t5_ready", 32'(bus_if.req_ready), 32'h2);
    tick();
    bus_if.req_valid = 4'd0;
    tick();
    tick();
    @(negedge clock);
    chk("t5_done", 32'(bus_if.done), 32'd1);
    chk("t5_done_id", 32'(bus_if.done_id), 32'd1);
    chk("t5_mis", 32'(bus_if.mismatch), 32'd0);
    tick();

    // Requester 3 arrives while requester 0 is in flight.
    do_reset();
    bus_if.req_valid = 4'b0001;
    bus_if.req_data  = 32'h7700_0007;
    tick();
    bus_if.req_valid = 4'b1000;
    @(negedge clock);
    chk("t6_ready_write", 32'(bus_if.req_ready), 32'd0);
    tick();
    @(negedge clock);
    chk("t6_ready_check", 32'(bus_if.req_ready), 32'd0);
    tick();
    @(negedge clock);
    chk("t6_done", 32'(bus_if.done), 32'd1);
    chk("t6_done_id", 32'(bus_if.done_id), 32'd0);
    chk("t6_ready_r3", 32'(bus_if.req_ready), 32'h8);
    tick();
    bus_if.req_valid = 4'd0;
    repeat (4) tick();

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      bus_if.req_valid = 4'($urandom);
      bus_if.req_data  = 32'($urandom);
      force_bad        = ($urandom_range(0, 9) == 0);
      clear            = ($urandom_range(0, 199) != 0);
      tick();
    end
    clear = 1'b1;
    force_bad = 1'b0;
    bus_if.req_valid = 4'd0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
